rx_frame_shift: RTL and testbench

- Parametrised successor to the fixed 11-bit receive shifter; deserialises one asynchronous serial frame on the i_Pclk domain.
- The frame is start, DATA_BITS data bits (LSB first), optional parity, then 1 or 2 stop bits.
- Timing comes from the existing baud generator, reprogrammed to deliver OVERSAMPLE ticks per bit. Each bit is decided by a 3-sample majority vote.
- Sits between the baud generator and the RX FIFO/register interface. Reports data, done, parity error, framing error and break.

---
 rtl/rx_frame_shift.sv | 186 ++++++++++++++++++
 tb/tb_rx_frame_shift.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_shift.sv
// rtl/rx_frame_shift.sv - oversampled asynchronous serial frame receiver
//
// Deserialises one start / DATA_BITS data (LSB first) / optional parity /
// 1-2 stop bit frame per o_Done, using a 3-sample majority vote per bit.
//
// Ports:
//   i_Pclk        system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Bclk        oversample enable, OVERSAMPLE pulses per bit period
//   i_Rx_Serial   asynchronous serial line, idle high
//   o_Data        received data, held until the next o_Done
//   o_Done        one-cycle pulse per completed frame
//   o_Parity_Err  parity mismatch for the frame flagged by o_Done
//   o_Frame_Err   a stop bit sampled low
//   o_Break       data, parity (if present) and first stop all low
//   o_Busy        high while a frame is being received
module rx_frame_shift #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_Pclk,
  input  logic                 i_Rst_n,
  input  logic                 i_Bclk,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Done,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q;
  logic [TW-1:0]        tick_q;
  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 samp0_q;
  logic                 samp1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 par_err_q;
  logic                 frame_err_q;
  logic                 stop0_q;

  logic [TW-1:0] tick_d;
  logic          wrap;
  logic          dec;
  logic          vote_d;
  logic          last_stop;
  logic          first_stop_d;
  logic          break_d;

  assign wrap   = (tick_q == TICK_LAST);
  assign dec    = (tick_q == TICK_DEC);
  assign tick_d = wrap ? '0 : tick_q + TW'(1);

  // Third sample is the live synchronised line at the decision tick.
  assign vote_d = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);

  assign last_stop    = (STOP_BITS == 1) || stop_idx_q;
  assign first_stop_d = stop_idx_q ? stop0_q : vote_d;
  assign break_d      = (shift_q == '0) && ((PARITY_EN == 0) || !par_bit_q) && !first_stop_d;

  assign o_Busy = (state_q != S_IDLE);

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      samp0_q      <= 1'b0;
      samp1_q      <= 1'b0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      stop0_q      <= 1'b0;
      o_Data       <= '0;
      o_Done       <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      o_Done    <= 1'b0;

      if (i_Bclk) begin
        if (state_q == S_IDLE) begin
          // The detecting tick is tick 0 of the start bit.
          if (!rx_s_q) begin
            state_q     <= S_START;
            tick_q      <= TW'(1);
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end else begin
          tick_q <= tick_d;
          if (tick_q == TICK_S0) samp0_q <= rx_s_q;
          if (tick_q == TICK_S1) samp1_q <= rx_s_q;

          case (state_q)
            S_START: begin
              if (dec && vote_d) begin
                state_q <= S_IDLE;
                tick_q  <= '0;
              end else if (wrap) begin
                state_q   <= S_DATA;
                bit_idx_q <= '0;
              end
            end
            S_DATA: begin
              if (dec) shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
              if (wrap) begin
                if (bit_idx_q == BIT_LAST) begin
                  bit_idx_q  <= '0;
                  stop_idx_q <= 1'b0;
                  state_q    <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                  bit_idx_q <= bit_idx_q + 4'd1;
                end
              end
            end
            S_PARITY: begin
              if (dec) begin
                par_bit_q <= vote_d;
                par_err_q <= ((^shift_q) ^ vote_d) != 1'(PARITY_ODD);
              end
              if (wrap) state_q <= S_STOP;
            end
            S_STOP: begin
              if (dec) begin
                if (!vote_d) frame_err_q <= 1'b1;
                if (!stop_idx_q) stop0_q <= vote_d;
                // Leave at the last decision so the next start edge is
                // caught even with no idle time after the stop bit.
                if (last_stop) begin
                  state_q      <= S_IDLE;
                  tick_q       <= '0;
                  o_Done       <= 1'b1;
                  o_Data       <= shift_q;
                  o_Parity_Err <= par_err_q;
                  o_Frame_Err  <= frame_err_q | !vote_d;
                  o_Break      <= break_d;
                end
              end else if (wrap) begin
                stop_idx_q <= 1'b1;
              end
            end
            default: begin
              state_q <= S_IDLE;
              tick_q  <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_shift.sv
// tb/tb_rx_frame_shift.sv - scoreboard bench for rx_frame_shift in three configurations
module tb_rx_frame_shift;

  localparam int OS = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bdiv  = 2'd0;
  logic       bclk;
  logic       rx_a  = 1'b1;
  logic       rx_b  = 1'b1;
  logic       rx_c  = 1'b1;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic done_a, pe_a, fe_a, brk_a, busy_a;
  logic done_b, pe_b, fe_b, brk_b, busy_b;
  logic done_c, pe_c, fe_c, brk_c, busy_c;
  logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // {break, frame_err, parity_err, data[8:0]}
  logic [11:0] qa[$];
  logic [11:0] qb[$];
  logic [11:0] qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) bdiv <= bdiv + 2'd1;
  assign bclk = (bdiv == 2'd3);

  rx_frame_shift u_a (
    .i_Pclk(clk), .i_Rst_n(rst_n), .i_Bclk(bclk), .i_Rx_Serial(rx_a),
    .o_Data(data_a), .o_Done(done_a), .o_Parity_Err(pe_a),
    .o_Frame_Err(fe_a), .o_Break(brk_a), .o_Busy(busy_a));

  rx_frame_shift #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .i_Pclk(clk), .i_Rst_n(rst_n), .i_Bclk(bclk), .i_Rx_Serial(rx_b),
    .o_Data(data_b), .o_Done(done_b), .o_Parity_Err(pe_b),
    .o_Frame_Err(fe_b), .o_Break(brk_b), .o_Busy(busy_b));

  rx_frame_shift #(.DATA_BITS(7), .STOP_BITS(2)) u_c (
    .i_Pclk(clk), .i_Rst_n(rst_n), .i_Bclk(bclk), .i_Rx_Serial(rx_c),
    .o_Data(data_c), .o_Done(done_c), .o_Parity_Err(pe_c),
    .o_Frame_Err(fe_c), .o_Break(brk_c), .o_Busy(busy_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!bclk) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_line(input int ch, input logic v);
    case (ch)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic drive_bit(input int ch, input logic v, input bit glitch);
    set_line(ch, v);
    if (glitch) begin
      wait_ticks(8);
      set_line(ch, ~v);
      wait_ticks(1);
      set_line(ch, v);
      wait_ticks(OS - 9);
    end else begin
      wait_ticks(OS);
    end
  endtask

  task automatic send_frame(input int ch, input logic [8:0] d, input int nd,
                            input logic par_en, input logic pbit, input int nstop,
                            input logic [1:0] stops, input int gbit);
    logic [8:0]  dm;
    logic [11:0] e;
    logic        pe, fe, brk;
    dm  = d & ((9'd1 << nd) - 9'd1);
    pe  = par_en & ((^dm) ^ pbit);
    fe  = ~stops[0] | ((nstop == 2) & ~stops[1]);
    brk = (dm == 9'd0) & (~par_en | ~pbit) & ~stops[0];
    e   = {brk, fe, pe, dm};
    case (ch)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
    drive_bit(ch, 1'b0, 1'b0);
    for (int i = 0; i < nd; i++) drive_bit(ch, dm[i], i == gbit);
    if (par_en) drive_bit(ch, pbit, 1'b0);
    for (int i = 0; i < nstop; i++) drive_bit(ch, stops[i], 1'b0);
    set_line(ch, 1'b1);
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (done_a) begin
      check_eq("a_done_width", prev_a, 0);
      check_eq("a_done_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check_eq("a_data", data_a, e[8:0]);
        check_eq("a_flags", {brk_a, fe_a, pe_a}, e[11:9]);
      end
    end
    if (done_b) begin
      check_eq("b_done_width", prev_b, 0);
      check_eq("b_done_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check_eq("b_data", data_b, e[8:0]);
        check_eq("b_flags", {brk_b, fe_b, pe_b}, e[11:9]);
      end
    end
    if (done_c) begin
      check_eq("c_done_width", prev_c, 0);
      check_eq("c_done_expected", qc.size() != 0, 1);
      if (qc.size() != 0) begin
        e = qc.pop_front();
        check_eq("c_data", data_c, e[8:0]);
        check_eq("c_flags", {brk_c, fe_c, pe_c}, e[11:9]);
      end
    end
    prev_a = done_a;
    prev_b = done_b;
    prev_c = done_c;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a", {data_a, done_a, pe_a, fe_a, brk_a, busy_a}, 0);
    check_eq("rst_b", {data_b, done_b, pe_b, fe_b, brk_b, busy_b}, 0);
    check_eq("rst_c", {data_c, done_c, pe_c, fe_c, brk_c, busy_c}, 0);
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 clean frame
    send_frame(0, 9'hA5, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    wait_ticks(20);

    // even parity: bad then good
    send_frame(1, 9'h03, 8, 1'b1, 1'b1, 1, 2'b11, -1);
    wait_ticks(20);
    send_frame(1, 9'h03, 8, 1'b1, 1'b0, 1, 2'b11, -1);
    wait_ticks(20);

    // framing error and break
    send_frame(0, 9'h5A, 8, 1'b0, 1'b0, 1, 2'b10, -1);
    wait_ticks(20);
    send_frame(0, 9'h00, 8, 1'b0, 1'b0, 1, 2'b10, -1);
    wait_ticks(20);
    send_frame(1, 9'h00, 8, 1'b1, 1'b0, 1, 2'b10, -1);
    wait_ticks(20);

    // short low glitch on idle line is a false start
    rx_a = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    check_eq("glitch_busy_hi", busy_a, 1);
    rx_a = 1'b1;
    wait_ticks(20);
    @(negedge clk);
    check_eq("glitch_busy_lo", busy_a, 0);

    // single-tick high glitch inside data bit 3
    send_frame(0, 9'h00, 8, 1'b0, 1'b0, 1, 2'b11, 3);
    wait_ticks(20);

    // reset during data bit 4; the partial frame must not complete
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
    wait_ticks(8);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", busy_a, 0);
    check_eq("midrst_done", done_a, 0);
    rx_a = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    wait_ticks(20);
    send_frame(0, 9'h3C, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    wait_ticks(20);

    // 7N2 back-to-back, then second stop low
    send_frame(2, 9'h41, 7, 1'b0, 1'b0, 2, 2'b11, -1);
    send_frame(2, 9'h7F, 7, 1'b0, 1'b0, 2, 2'b11, -1);
    send_frame(2, 9'h55, 7, 1'b0, 1'b0, 2, 2'b01, -1);
    wait_ticks(40);

    check_eq("qa_drained", qa.size(), 0);
    check_eq("qb_drained", qb.size(), 0);
    check_eq("qc_drained", qc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
